// File: rtl/mem_access_store_if.sv
// Execute-to-memory-stage request bus and 16-bit data-memory port.
// master: the execute side (drives requests, observes the memory port).
// slave:  the mem_access_store stage.
interface mem_access_store_if #(
    parameter int unsigned ADDR_W = 32
);
    // Request from execute
    logic [ADDR_W-1:0] addr_i;
    logic [31:0]       store_data_i;
    logic              store_i;
    logic              load_i;
    logic              half_i;

    // Data-memory port and pipeline control
    logic [ADDR_W-1:0] mem_addr_o;
    logic [15:0]       mem_wdata_o;
    logic              mem_we_o;
    logic              mem_re_o;
    logic              mem_to_reg_o;
    logic              stall_o;
    logic              err_o;

    modport master (
        output addr_i, store_data_i, store_i, load_i, half_i,
        input  mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
               mem_to_reg_o, stall_o, err_o
    );

    modport slave (
        input  addr_i, store_data_i, store_i, load_i, half_i,
        output mem_addr_o, mem_wdata_o, mem_we_o, mem_re_o,
               mem_to_reg_o, stall_o, err_o
    );
endinterface

// File: rtl/mem_access_store.sv
// Memory-access stage: splits 32-bit loads/stores into two 16-bit beats
// (low half at addr, high half at addr+HALF_STEP) on the data-memory port.
// The first beat is driven combinationally in the request cycle; the high
// beat comes from registered state in the following cycle.
// Optional feature macro: MEM_ALIGN_CHK_EN (rejects requests with addr_i[0]=1).
module mem_access_store #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned HALF_STEP = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_access_store_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_HIGH = 2'd1,
        RD_HIGH = 2'd2
    } state_t;

    state_t              state_q;
    logic [15:0]         hi_reg;
    logic [ADDR_W-1:0]   addr_reg;

    logic                idle_c;
    logic                bad_align_c;
    logic                store_go_c;
    logic                load_go_c;
    logic                conflict_c;
    logic [ADDR_W-1:0]   addr_hi_c;

    logic [ADDR_W-1:0]   mem_addr_c;
    logic [15:0]         mem_wdata_c;
    logic                mem_we_c;
    logic                mem_re_c;
    logic                mem_to_reg_c;
    logic                stall_c;
    logic                err_c;

    assign idle_c = (state_q == IDLE);

    // Misaligned-request detection (only when the alignment check is built in)
`ifdef MEM_ALIGN_CHK_EN
    assign bad_align_c = (bus.store_i | bus.load_i) & bus.addr_i[0];
`else
    assign bad_align_c = 1'b0;
`endif

    // Request acceptance: stores win over loads; nothing accepted outside IDLE
    assign store_go_c = idle_c & bus.store_i & ~bad_align_c;
    assign load_go_c  = idle_c & bus.load_i & ~bus.store_i & ~bad_align_c;
    assign conflict_c = idle_c & bus.store_i & bus.load_i;

    // High-half address, wrapping modulo 2^ADDR_W
    assign addr_hi_c = bus.addr_i + ADDR_W'(HALF_STEP);

    // State and high-beat capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hi_reg   <= 16'h0000;
            addr_reg <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (store_go_c && !bus.half_i) begin
                        hi_reg   <= bus.store_data_i[31:16];
                        addr_reg <= addr_hi_c;
                        state_q  <= WR_HIGH;
                    end else if (load_go_c && !bus.half_i) begin
                        addr_reg <= addr_hi_c;
                        state_q  <= RD_HIGH;
                    end
                end
                WR_HIGH: state_q <= IDLE;
                RD_HIGH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory-port and pipeline-control decode; everything held at 0 in reset
    always_comb begin
        mem_addr_c   = '0;
        mem_wdata_c  = 16'h0000;
        mem_we_c     = 1'b0;
        mem_re_c     = 1'b0;
        mem_to_reg_c = 1'b0;
        stall_c      = 1'b0;
        err_c        = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    mem_addr_c = bus.addr_i;
                    err_c      = conflict_c | bad_align_c;
                    if (store_go_c) begin
                        mem_wdata_c = bus.store_data_i[15:0];
                        mem_we_c    = 1'b1;
                        stall_c     = ~bus.half_i;
                    end else if (load_go_c) begin
                        mem_re_c     = 1'b1;
                        mem_to_reg_c = 1'b1;
                        stall_c      = ~bus.half_i;
                    end
                end
                WR_HIGH: begin
                    mem_addr_c  = addr_reg;
                    mem_wdata_c = hi_reg;
                    mem_we_c    = 1'b1;
                end
                RD_HIGH: begin
                    mem_addr_c   = addr_reg;
                    mem_re_c     = 1'b1;
                    mem_to_reg_c = 1'b1;
                end
                default: begin
                    mem_addr_c = bus.addr_i;
                end
            endcase
        end
    end

    assign bus.mem_addr_o   = mem_addr_c;
    assign bus.mem_wdata_o  = mem_wdata_c;
    assign bus.mem_we_o     = mem_we_c;
    assign bus.mem_re_o     = mem_re_c;
    assign bus.mem_to_reg_o = mem_to_reg_c;
    assign bus.stall_o      = stall_c;
    assign bus.err_o        = err_c;

    // Read and write enables are mutually exclusive
    a_we_re_excl: assert property (@(posedge clk_i) !(mem_we_c && mem_re_c));

endmodule

// File: tb/tb_mem_access_store.sv
// Directed bench for mem_access_store: inputs change 1 time unit after the
// rising edge, outputs are sampled on the falling edge.
module tb_mem_access_store;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_access_store_if #(.ADDR_W(32)) bus ();

    mem_access_store #(
        .ADDR_W    (32),
        .HALF_STEP (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic st, input logic ld, input logic hf,
                       input logic [31:0] a, input logic [31:0] d);
        bus.store_i      = st;
        bus.load_i       = ld;
        bus.half_i       = hf;
        bus.addr_i       = a;
        bus.store_data_i = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset with a word store presented: everything held at 0
        #1;
        req(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'hCAFE_F00D);
        @(negedge clk);
        check("rst_we",    64'(bus.mem_we_o),    64'h0);
        check("rst_addr",  64'(bus.mem_addr_o),  64'h0);
        check("rst_wdata", 64'(bus.mem_wdata_o), 64'h0);
        check("rst_stall", 64'(bus.stall_o),     64'h0);
        check("rst_err",   64'(bus.err_o),       64'h0);
        next_cycle();

        // Out of reset, no request: no WR_HIGH beat from the reset-cycle store
        rst = 1'b0;
        req(1'b0, 1'b0, 1'b0, 32'h0000_0555, 32'h0);
        @(negedge clk);
        check("post_rst_we",   64'(bus.mem_we_o),   64'h0);
        check("post_rst_addr", 64'(bus.mem_addr_o), 64'h555);
        next_cycle();

        // Word store 0x100 / 0xDEADBEEF
        req(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ws0_addr",  64'(bus.mem_addr_o),  64'h100);
        check("ws0_wdata", 64'(bus.mem_wdata_o), 64'hBEEF);
        check("ws0_we",    64'(bus.mem_we_o),    64'h1);
        check("ws0_re",    64'(bus.mem_re_o),    64'h0);
        check("ws0_stall", 64'(bus.stall_o),     64'h1);
        next_cycle();
        // Second beat; a load presented now must be ignored
        req(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        @(negedge clk);
        check("ws1_addr",  64'(bus.mem_addr_o),   64'h102);
        check("ws1_wdata", 64'(bus.mem_wdata_o),  64'hDEAD);
        check("ws1_we",    64'(bus.mem_we_o),     64'h1);
        check("ws1_re",    64'(bus.mem_re_o),     64'h0);
        check("ws1_m2r",   64'(bus.mem_to_reg_o), 64'h0);
        check("ws1_stall", 64'(bus.stall_o),      64'h0);
        next_cycle();

        // Idle
        req(1'b0, 1'b0, 1'b0, 32'h0000_0123, 32'h0);
        @(negedge clk);
        check("idle_we",   64'(bus.mem_we_o),   64'h0);
        check("idle_re",   64'(bus.mem_re_o),   64'h0);
        check("idle_addr", 64'(bus.mem_addr_o), 64'h123);
        next_cycle();

        // Word load 0x200
        req(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0);
        @(negedge clk);
        check("wl0_addr",  64'(bus.mem_addr_o),   64'h200);
        check("wl0_re",    64'(bus.mem_re_o),     64'h1);
        check("wl0_we",    64'(bus.mem_we_o),     64'h0);
        check("wl0_m2r",   64'(bus.mem_to_reg_o), 64'h1);
        check("wl0_stall", 64'(bus.stall_o),      64'h1);
        next_cycle();
        req(1'b0, 1'b0, 1'b0, 32'h0000_0999, 32'h0);
        @(negedge clk);
        check("wl1_addr",  64'(bus.mem_addr_o),   64'h202);
        check("wl1_re",    64'(bus.mem_re_o),     64'h1);
        check("wl1_m2r",   64'(bus.mem_to_reg_o), 64'h1);
        check("wl1_stall", 64'(bus.stall_o),      64'h0);
        next_cycle();

        // Halfword store 0x10 / 0x1234ABCD
        req(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h1234_ABCD);
        @(negedge clk);
        check("hs_addr",  64'(bus.mem_addr_o),  64'h10);
        check("hs_wdata", 64'(bus.mem_wdata_o), 64'hABCD);
        check("hs_we",    64'(bus.mem_we_o),    64'h1);
        check("hs_stall", 64'(bus.stall_o),     64'h0);
        next_cycle();
        req(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge clk);
        check("hs_done_we",    64'(bus.mem_we_o), 64'h0);
        check("hs_done_stall", 64'(bus.stall_o),  64'h0);
        next_cycle();

        // Halfword load 0x20
        req(1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0);
        @(negedge clk);
        check("hl_re",    64'(bus.mem_re_o),     64'h1);
        check("hl_m2r",   64'(bus.mem_to_reg_o), 64'h1);
        check("hl_stall", 64'(bus.stall_o),      64'h0);
        next_cycle();

        // Word store at top of address space, immediately after the halfword load
        req(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h5566_7788);
        @(negedge clk);
        check("wrap0_addr",  64'(bus.mem_addr_o),  64'hFFFF_FFFE);
        check("wrap0_wdata", 64'(bus.mem_wdata_o), 64'h7788);
        next_cycle();
        req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("wrap1_addr",  64'(bus.mem_addr_o),  64'h0);
        check("wrap1_wdata", 64'(bus.mem_wdata_o), 64'h5566);
        check("wrap1_we",    64'(bus.mem_we_o),    64'h1);
        next_cycle();

        // Store and load together: store wins, err pulses one cycle
        req(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h1111_2222);
        @(negedge clk);
        check("cf0_err",   64'(bus.err_o),        64'h1);
        check("cf0_we",    64'(bus.mem_we_o),     64'h1);
        check("cf0_re",    64'(bus.mem_re_o),     64'h0);
        check("cf0_m2r",   64'(bus.mem_to_reg_o), 64'h0);
        check("cf0_wdata", 64'(bus.mem_wdata_o),  64'h2222);
        check("cf0_stall", 64'(bus.stall_o),      64'h1);
        next_cycle();
        @(negedge clk);
        check("cf1_err",   64'(bus.err_o),       64'h0);
        check("cf1_addr",  64'(bus.mem_addr_o),  64'h302);
        check("cf1_wdata", 64'(bus.mem_wdata_o), 64'h1111);
        check("cf1_re",    64'(bus.mem_re_o),    64'h0);
        next_cycle();

        // Reset while the high beat is pending: it is never issued
        req(1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'hAAAA_BBBB);
        @(negedge clk);
        check("mr0_we", 64'(bus.mem_we_o), 64'h1);
        next_cycle();
        rst = 1'b1;
        req(1'b0, 1'b0, 1'b0, 32'h0000_0777, 32'h0);
        @(negedge clk);
        check("mr1_we",    64'(bus.mem_we_o),    64'h0);
        check("mr1_addr",  64'(bus.mem_addr_o),  64'h0);
        check("mr1_wdata", 64'(bus.mem_wdata_o), 64'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("mr2_we",   64'(bus.mem_we_o),   64'h0);
        check("mr2_addr", 64'(bus.mem_addr_o), 64'h777);
        next_cycle();

        // Odd address store
        req(1'b1, 1'b0, 1'b1, 32'h0000_0101, 32'h0000_4321);
        @(negedge clk);
`ifdef MEM_ALIGN_CHK_EN
        check("mis_we",    64'(bus.mem_we_o), 64'h0);
        check("mis_stall", 64'(bus.stall_o),  64'h0);
        check("mis_err",   64'(bus.err_o),    64'h1);
`else
        check("odd_we",    64'(bus.mem_we_o),    64'h1);
        check("odd_addr",  64'(bus.mem_addr_o),  64'h101);
        check("odd_wdata", 64'(bus.mem_wdata_o), 64'h4321);
        check("odd_err",   64'(bus.err_o),       64'h0);
`endif
        next_cycle();
        req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("odd_done_err", 64'(bus.err_o),    64'h0);
        check("odd_done_we",  64'(bus.mem_we_o), 64'h0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
